// File: rtl/exu_rf_rd_arb.sv
// Round-robin arbiter sharing the register file's two read ports among NUM_REQ EXU sub-units.
// Grants and RF read controls are registered; responses are tagged back to the winner RF_LAT cycles later.
module exu_rf_rd_arb #(
  parameter int NUM_REQ = 4,
  parameter int RF_LAT  = 1
) (
  input  logic                 hclk,
  input  logic                 hrstn,
  input  logic                 exu_stall,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [5*NUM_REQ-1:0] req_raddr_1,
  input  logic [NUM_REQ-1:0]   req_ren_1,
  input  logic [5*NUM_REQ-1:0] req_raddr_2,
  input  logic [NUM_REQ-1:0]   req_ren_2,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [31:0]          rsp_rdata_1,
  output logic [31:0]          rsp_rdata_2,
  output logic [4:0]           reg_raddr_1,
  output logic                 reg_ren_1,
  input  logic [31:0]          reg_rdata_1,
  output logic [4:0]           reg_raddr_2,
  output logic                 reg_ren_2,
  input  logic [31:0]          reg_rdata_2
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]              ptr;
  logic [PTR_W-1:0]              win_idx;
  logic [PTR_W-1:0]              next_ptr;
  logic                          win_valid;
  logic                          grant_en;
  logic [RF_LAT-1:0][NUM_REQ-1:0] rsp_pipe;

  // Scan offsets from the highest down so the smallest offset from ptr is the last to win.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NUM_REQ]) begin
        win_valid = 1'b1;
        win_idx   = PTR_W'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end

  assign grant_en = win_valid & ~exu_stall;
  assign next_ptr = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + PTR_W'(1);

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      ptr         <= '0;
      gnt         <= '0;
      reg_ren_1   <= 1'b0;
      reg_ren_2   <= 1'b0;
      reg_raddr_1 <= '0;
      reg_raddr_2 <= '0;
    end else begin
      gnt         <= '0;
      reg_ren_1   <= 1'b0;
      reg_ren_2   <= 1'b0;
      reg_raddr_1 <= '0;
      reg_raddr_2 <= '0;
      if (grant_en) begin
        gnt[win_idx] <= 1'b1;
        reg_ren_1    <= req_ren_1[win_idx];
        reg_ren_2    <= req_ren_2[win_idx];
        reg_raddr_1  <= req_ren_1[win_idx] ? req_raddr_1[5*win_idx +: 5] : 5'd0;
        reg_raddr_2  <= req_ren_2[win_idx] ? req_raddr_2[5*win_idx +: 5] : 5'd0;
        ptr          <= next_ptr;
      end
    end
  end

  // The response pipe keeps moving during stalls so issued reads always complete on time.
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      rsp_pipe <= '0;
    end else begin
      rsp_pipe[0] <= gnt;
      for (int i = 1; i < RF_LAT; i++) begin
        rsp_pipe[i] <= rsp_pipe[i-1];
      end
    end
  end

  assign rsp_valid   = rsp_pipe[RF_LAT-1];
  assign rsp_rdata_1 = reg_rdata_1;
  assign rsp_rdata_2 = reg_rdata_2;

endmodule

// File: tb/tb_exu_rf_rd_arb.sv
// Self-checking bench for exu_rf_rd_arb: directed scenarios plus randomized traffic against a reference model.
// Two instances (RF_LAT=1 and RF_LAT=2) share all stimulus.
module tb_exu_rf_rd_arb;
  localparam int N = 4;

  logic           hclk = 1'b0;
  logic           hrstn;
  logic           exu_stall;
  logic [N-1:0]   req, req_ren_1, req_ren_2;
  logic [5*N-1:0] req_raddr_1, req_raddr_2;
  logic [31:0]    reg_rdata_1, reg_rdata_2;

  logic [N-1:0] gnt_a, rsp_valid_a, gnt_b, rsp_valid_b;
  logic [31:0]  rsp_rdata_1_a, rsp_rdata_2_a, rsp_rdata_1_b, rsp_rdata_2_b;
  logic [4:0]   reg_raddr_1_a, reg_raddr_2_a, reg_raddr_1_b, reg_raddr_2_b;
  logic         reg_ren_1_a, reg_ren_2_a, reg_ren_1_b, reg_ren_2_b;

  exu_rf_rd_arb #(.NUM_REQ(N), .RF_LAT(1)) dut_a (
    .hclk(hclk), .hrstn(hrstn), .exu_stall(exu_stall), .req(req),
    .req_raddr_1(req_raddr_1), .req_ren_1(req_ren_1), .req_raddr_2(req_raddr_2), .req_ren_2(req_ren_2),
    .gnt(gnt_a), .rsp_valid(rsp_valid_a), .rsp_rdata_1(rsp_rdata_1_a), .rsp_rdata_2(rsp_rdata_2_a),
    .reg_raddr_1(reg_raddr_1_a), .reg_ren_1(reg_ren_1_a), .reg_rdata_1(reg_rdata_1),
    .reg_raddr_2(reg_raddr_2_a), .reg_ren_2(reg_ren_2_a), .reg_rdata_2(reg_rdata_2)
  );

  exu_rf_rd_arb #(.NUM_REQ(N), .RF_LAT(2)) dut_b (
    .hclk(hclk), .hrstn(hrstn), .exu_stall(exu_stall), .req(req),
    .req_raddr_1(req_raddr_1), .req_ren_1(req_ren_1), .req_raddr_2(req_raddr_2), .req_ren_2(req_ren_2),
    .gnt(gnt_b), .rsp_valid(rsp_valid_b), .rsp_rdata_1(rsp_rdata_1_b), .rsp_rdata_2(rsp_rdata_2_b),
    .reg_raddr_1(reg_raddr_1_b), .reg_ren_1(reg_ren_1_b), .reg_rdata_1(reg_rdata_1),
    .reg_raddr_2(reg_raddr_2_b), .reg_ren_2(reg_ren_2_b), .reg_rdata_2(reg_rdata_2)
  );

  always #5 hclk = ~hclk;

  int total = 0;
  int bad   = 0;

  // Reference state: hist[k] is the grant vector issued k cycles ago.
  int         m_ptr;
  logic [N-1:0] hist [3];
  logic       e_ren1, e_ren2;
  logic [4:0] e_raddr1, e_raddr2;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_ptr = 0;
    for (int k = 0; k < 3; k++) hist[k] = '0;
    e_ren1 = 1'b0; e_ren2 = 1'b0; e_raddr1 = '0; e_raddr2 = '0;
  endtask

  // Rotate req so ptr sits at bit 0, take the lowest set bit, then rotate back.
  task automatic modelEdge();
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             off, w;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = '0;
    e_ren1 = 1'b0; e_ren2 = 1'b0; e_raddr1 = '0; e_raddr2 = '0;
    if (!exu_stall && req != '0) begin
      dbl = {req, req} >> m_ptr;
      rot = dbl[N-1:0];
      off = 0;
      while (!rot[off]) off++;
      w = (m_ptr + off) % N;
      hist[0][w] = 1'b1;
      e_ren1   = req_ren_1[w];
      e_ren2   = req_ren_2[w];
      e_raddr1 = e_ren1 ? req_raddr_1[5*w +: 5] : 5'd0;
      e_raddr2 = e_ren2 ? req_raddr_2[5*w +: 5] : 5'd0;
      m_ptr    = (w + 1) % N;
    end
  endtask

  task automatic checkAll();
    checkOutput("gnt_a", gnt_a, hist[0]);
    checkOutput("gnt_b", gnt_b, hist[0]);
    checkOutput("ren1_a", reg_ren_1_a, e_ren1);
    checkOutput("ren2_a", reg_ren_2_a, e_ren2);
    checkOutput("raddr1_a", reg_raddr_1_a, e_raddr1);
    checkOutput("raddr2_a", reg_raddr_2_a, e_raddr2);
    checkOutput("ren1_b", reg_ren_1_b, e_ren1);
    checkOutput("raddr2_b", reg_raddr_2_b, e_raddr2);
    checkOutput("rsp_valid_a", rsp_valid_a, hist[1]);
    checkOutput("rsp_valid_b", rsp_valid_b, hist[2]);
    checkOutput("rdata1_a", rsp_rdata_1_a, reg_rdata_1);
    checkOutput("rdata2_b", rsp_rdata_2_b, reg_rdata_2);
  endtask

  task automatic step();
    @(posedge hclk);
    if (hrstn) modelEdge();
    #1;
    checkAll();
  endtask

  task automatic applyStimulus(input logic stall, input logic [N-1:0] r,
                               input logic [N-1:0] en1, input logic [N-1:0] en2,
                               input logic [5*N-1:0] a1, input logic [5*N-1:0] a2);
    exu_stall   = stall;
    req         = r;
    req_ren_1   = en1;
    req_ren_2   = en2;
    req_raddr_1 = a1;
    req_raddr_2 = a2;
  endtask

  task automatic doReset();
    @(negedge hclk);
    hrstn = 1'b0;
    modelReset();
    #1;
    checkAll();
    step();
    @(negedge hclk);
    hrstn = 1'b1;
  endtask

  initial begin
    hrstn = 1'b0;
    applyStimulus(1'b0, '0, '0, '0, '0, '0);
    reg_rdata_1 = '0;
    reg_rdata_2 = '0;
    modelReset();
    #12;
    checkAll();
    @(negedge hclk);
    hrstn = 1'b1;

    // T1: single request, both ports
    applyStimulus(1'b0, 4'b0001, 4'b0001, 4'b0001, 20'd5, 20'd7);
    reg_rdata_1 = 32'hAAAA;
    reg_rdata_2 = 32'h5555;
    step();
    checkOutput("t1_gnt", gnt_a, 32'h1);
    checkOutput("t1_raddr1", reg_raddr_1_a, 32'd5);
    checkOutput("t1_raddr2", reg_raddr_2_a, 32'd7);
    applyStimulus(1'b0, '0, '0, '0, '0, '0);
    step();
    checkOutput("t1_rsp", rsp_valid_a, 32'h1);
    checkOutput("t1_rd1", rsp_rdata_1_a, 32'hAAAA);
    checkOutput("t1_rd2", rsp_rdata_2_a, 32'h5555);
    step();

    // T2: all four request, each drops after its grant
    doReset();
    applyStimulus(1'b0, 4'b1111, 4'b1111, 4'b0000, 20'hFEDCB, 20'h12345);
    for (int k = 0; k < N; k++) begin
      step();
      checkOutput("t2_gnt", gnt_a, 32'(1 << k));
      req = req & ~hist[0];
    end
    checkOutput("t2_ptr", m_ptr, 32'd0);

    // T3: move ptr to 2, then persistent req 0011 alternates
    applyStimulus(1'b0, 4'b0010, 4'b0000, 4'b0000, '0, '0);
    step();
    req = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      step();
      checkOutput("t3_gnt", gnt_a, (k % 2 == 0) ? 32'h1 : 32'h2);
    end

    // T4: stall with a response in flight
    applyStimulus(1'b0, 4'b0001, 4'b0001, 4'b0000, 20'd3, '0);
    step();
    applyStimulus(1'b1, 4'b0100, 4'b0100, 4'b0100, 20'h00C00, 20'h00D00);
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput("t4_gnt_stalled", gnt_a, 32'h0);
      if (k == 0) checkOutput("t4_rsp_inflight", rsp_valid_a, 32'h1);
    end
    exu_stall = 1'b0;
    step();
    checkOutput("t4_gnt_after", gnt_a, 32'h4);
    req = '0;
    step();

    // T5: port 1 unused, port 2 reads r31
    applyStimulus(1'b0, 4'b0010, 4'b0000, 4'b0010, 20'h00120, 20'h003E0);
    step();
    checkOutput("t5_ren1", reg_ren_1_a, 32'h0);
    checkOutput("t5_raddr1", reg_raddr_1_a, 32'h0);
    checkOutput("t5_raddr2", reg_raddr_2_a, 32'd31);
    req = '0;
    step();
    checkOutput("t5_rsp", rsp_valid_a, 32'h2);

    // T6: reset right after a grant drops the RF_LAT=2 response
    applyStimulus(1'b0, 4'b0100, 4'b0100, 4'b0000, 20'h01400, '0);
    step();
    req = '0;
    @(negedge hclk);
    hrstn = 1'b0;
    modelReset();
    #1;
    checkAll();
    step();
    @(negedge hclk);
    hrstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput("t6_no_rsp", rsp_valid_b, 32'h0);
    end
    req = 4'b1001;
    step();
    checkOutput("t6_gnt_from0", gnt_b, 32'h1);
    req = '0;
    step();

    // Randomized traffic: requests held until granted, random stalls and RF data
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && hist[0][i]) begin
          req[i] = ($urandom_range(0, 1) == 1);
        end else if (!req[i]) begin
          req[i] = ($urandom_range(0, 9) < 4);
        end else begin
          continue;
        end
        req_ren_1[i] = 1'($urandom);
        req_ren_2[i] = 1'($urandom);
        req_raddr_1[5*i +: 5] = 5'($urandom);
        req_raddr_2[5*i +: 5] = 5'($urandom);
      end
      exu_stall   = ($urandom_range(0, 4) == 0);
      reg_rdata_1 = $urandom;
      reg_rdata_2 = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
